parity_frame_ctrl: RTL
======================

Name: parity_frame_ctrl

Overview:
Sequences a stream of N-bit data words through an N-bit XOR-reduce parity check, frame by frame. Each accepted word carries a received parity bit. The block compares it against the computed parity, counts mismatches per frame and in total, and signals frame completion. It sits between an upstream word source (valid/ready) and the status/CSR logic.

Parameters:
N, 4, data word width in bits (>=1)
FRAME_LEN, 8, words per frame (>=2)
CNT_W, 8, width of the error counters
ODD, 0, 0 = even parity (expected bit = ^data); 1 = odd parity (expected bit = ~^data)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  pulse; begins a frame when idle
clear_err  input  1  clears total_err_cnt and sticky_err
in_valid  input  1  upstream word valid
in_ready  output  1  block accepting words
in_data  input  N  data word
in_parity  input  1  received parity bit for in_data
busy  output  1  high in RUN and REPORT
err_pulse  output  1  one-cycle pulse, registered, one cycle after a mismatching transfer
frame_done  output  1  one-cycle pulse in REPORT
frame_err_cnt  output  CNT_W  mismatches in current/last frame
total_err_cnt  output  CNT_W  mismatches since reset/clear
sticky_err  output  1  set on any mismatch; held until clear_err or rst

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset, also mid-frame: state=IDLE, word counter=0, all outputs 0. A partial frame is discarded, with no frame_done.
- FSM states: IDLE, RUN, REPORT. All outputs are registered except in_ready, which is high exactly when state==RUN.
- IDLE:
  - start=1: go to RUN, word_cnt=0, frame_err_cnt=0.
  - Otherwise stay in IDLE.
- start is ignored in RUN and REPORT.
- RUN:
  - A transfer happens when in_valid && in_ready.
  - mismatch = (^in_data ^ ODD) != in_parity.
  - On a mismatching transfer: next edge frame_err_cnt+1, total_err_cnt+1, sticky_err=1, err_pulse=1.
  - word_cnt increments on each transfer. The transfer with word_cnt==FRAME_LEN-1 moves the FSM to REPORT.
  - Bubbles (in_valid=0) just hold state. There is no timeout.
- REPORT:
  - Lasts exactly one cycle with frame_done=1, then goes to IDLE.
  - frame_err_cnt already includes the last word.
  - frame_err_cnt holds until the next accepted start.
- Latency: the last word is accepted on edge k; frame_done is high during cycle k+1. A new start is accepted in IDLE on cycle k+2 at the earliest.
- Counters saturate at 2^CNT_W-1; they do not wrap.
- clear_err:
  - Clears total_err_cnt and sticky_err on the next edge in any state.
  - If it coincides with a mismatching transfer, the clear applies first and the mismatch is then counted: total_err_cnt=1, sticky_err=1.
  - Does not affect frame_err_cnt.
- Word counter width: $clog2(FRAME_LEN).

Optional Feature:
PARITY_ABORT_EN:
- Defined: the first mismatching transfer in RUN ends the frame immediately.
  - FSM goes to REPORT; frame_done pulses.
  - frame_err_cnt=1, and the remaining words are not requested.
- Undefined: every frame always consumes exactly FRAME_LEN words regardless of errors.

Test Plan:
- Reset, then start pulse; 8 words with correct even parity: data 0000/0001/0011/0111/1111/1010/0110/1000 with parity 0/1/0/1/0/0/0/1 -> frame_done 1 cycle after 8th transfer, frame_err_cnt=0, err_pulse never high.
- Same frame with the parity bit of words 2 and 5 inverted -> err_pulse high twice, frame_err_cnt=2, total_err_cnt=2, sticky_err=1. A second clean frame -> frame_err_cnt=0, total_err_cnt=2.
- in_valid toggled every other cycle, plus start asserted mid-RUN -> frame still ends after exactly 8 transfers; start has no effect.
- total_err_cnt at 255 (CNT_W=8) plus one more mismatch -> stays 255. clear_err in the same cycle as a mismatch -> total_err_cnt=1, sticky_err=1.
- rst asserted after the 3rd word -> next cycle IDLE, all outputs 0, no frame_done.
- With PARITY_ABORT_EN, mismatch on word 3 -> REPORT next cycle, frame_err_cnt=1, in_ready low thereafter. Without the macro -> 8 words consumed.

Source files
------------

// File: rtl/parity_frame_ctrl.sv
// Frame-sequenced parity checker: counts received-parity mismatches per frame and in total.
// Optional: define PARITY_ABORT_EN to end a frame on its first mismatching word.
module parity_frame_ctrl #(
   parameter int N         = 4,
   parameter int FRAME_LEN = 8,
   parameter int CNT_W     = 8,
   parameter int ODD       = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             clear_err,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   input  logic             in_parity,
   output logic             busy,
   output logic             err_pulse,
   output logic             frame_done,
   output logic [CNT_W-1:0] frame_err_cnt,
   output logic [CNT_W-1:0] total_err_cnt,
   output logic             sticky_err
);

   localparam int WCW = $clog2(FRAME_LEN);
   localparam logic [WCW-1:0] LAST = WCW'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic ODD_B = (ODD != 0);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      REPORT
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WCW-1:0]   word_cnt;
   logic [WCW-1:0]   word_cnt_nx;
   logic [CNT_W-1:0] frame_err_nx;
   logic [CNT_W-1:0] total_base;
   logic [CNT_W-1:0] total_err_nx;
   logic             sticky_nx;
   logic             xfer;
   logic             mismatch;
   logic             last_word;
   logic             abort;

   assign in_ready  = (state == RUN);
   assign xfer      = in_valid & in_ready;
   assign mismatch  = xfer & (((^in_data) ^ ODD_B) != in_parity);
   assign last_word = (word_cnt == LAST);

`ifdef PARITY_ABORT_EN
   assign abort = mismatch;
`else
   assign abort = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         word_cnt <= '0;
      end else begin
         state    <= state_nx;
         word_cnt <= word_cnt_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      word_cnt_nx = word_cnt;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nx    = RUN;
               word_cnt_nx = '0;
            end
         end
         RUN: begin
            if (xfer) begin
               word_cnt_nx = word_cnt + 1'b1;
               if (last_word || abort)
                  state_nx = REPORT;
            end
         end
         REPORT: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // clear_err takes effect before a coincident mismatch is counted
   always_comb begin
      frame_err_nx = frame_err_cnt;
      if (state == IDLE && start)
         frame_err_nx = '0;
      else if (mismatch && frame_err_cnt != CNT_MAX)
         frame_err_nx = frame_err_cnt + 1'b1;

      total_base   = clear_err ? '0 : total_err_cnt;
      total_err_nx = total_base;
      if (mismatch && total_base != CNT_MAX)
         total_err_nx = total_base + 1'b1;

      sticky_nx = (sticky_err & ~clear_err) | mismatch;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy          <= 1'b0;
         err_pulse     <= 1'b0;
         frame_done    <= 1'b0;
         frame_err_cnt <= '0;
         total_err_cnt <= '0;
         sticky_err    <= 1'b0;
      end else begin
         busy          <= (state_nx != IDLE);
         err_pulse     <= mismatch;
         frame_done    <= (state_nx == REPORT);
         frame_err_cnt <= frame_err_nx;
         total_err_cnt <= total_err_nx;
         sticky_err    <= sticky_nx;
      end
   end

endmodule
